// File: rtl/hazard_scoreboard_unit_pkg.sv
// hazard_pkg: shared defaults, FSM encoding and width helper for the hazard scoreboard.
package hazard_pkg;
    localparam int REG_AW_DEF = 5;

    typedef enum logic {IDLE, FLUSH} fsmState_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// hazard_scoreboard_unit_if: DEC-side inputs and pipeline-control outputs of the scoreboard.
// Optional perf counters appear when HAZARD_PERF_EN is defined.
interface hazard_scoreboard_unit_if #(
    parameter int REG_AW   = hazard_pkg::REG_AW_DEF,
    parameter int NUM_REGS = 2 ** REG_AW
);
    logic              dec_valid;
    logic [REG_AW-1:0] Rs_DEC;
    logic [REG_AW-1:0] Rt_DEC;
    logic              RsUse_DEC;
    logic              RtUse_DEC;
    logic [REG_AW-1:0] RegDst_DEC;
    logic              RegWrite_DEC;
    logic              BranchAND;
    logic              Jump;
    logic              JumpRegister;
    logic              PC_write;
    logic              IFID_write;
    logic              IF_flush;
    logic              stall_IDEX;
    logic [NUM_REGS-1:0] busy_mask;
`ifdef HAZARD_PERF_EN
    logic [31:0]       stall_cycles;
    logic [31:0]       flush_cycles;
`endif

    modport master (
        output dec_valid, Rs_DEC, Rt_DEC, RsUse_DEC, RtUse_DEC, RegDst_DEC, RegWrite_DEC,
        output BranchAND, Jump, JumpRegister,
`ifdef HAZARD_PERF_EN
        input  stall_cycles, flush_cycles,
`endif
        input  PC_write, IFID_write, IF_flush, stall_IDEX, busy_mask
    );

    modport slave (
        input  dec_valid, Rs_DEC, Rt_DEC, RsUse_DEC, RtUse_DEC, RegDst_DEC, RegWrite_DEC,
        input  BranchAND, Jump, JumpRegister,
`ifdef HAZARD_PERF_EN
        output stall_cycles, flush_cycles,
`endif
        output PC_write, IFID_write, IF_flush, stall_IDEX, busy_mask
    );
endinterface

// File: rtl/hazard_scoreboard_unit_pending_counter.sv
// hazard_pending_counter: per-register countdown of cycles until a pending write lands.
module hazard_pending_counter #(
    parameter int W = 2
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         busy
);
    logic [W-1:0] cnt;

    always_ff @(posedge Clk) begin
        if (Reset) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - W'(1);
    end

    assign busy = (cnt != '0);
endmodule

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: pending-write scoreboard plus multi-slot redirect-flush FSM beside DEC.
// Define HAZARD_PERF_EN to add stall/flush cycle counters.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW      = REG_AW_DEF,
    parameter int NUM_REGS    = 2 ** REG_AW,
    parameter int WB_LAT      = 3,
    parameter int FLUSH_SLOTS = 1
) (
    input  logic Clk,
    input  logic Reset,
    hazard_scoreboard_unit_if.slave bus
);
    localparam int CW = clog2(WB_LAT + 1);

    logic [NUM_REGS-1:0] busy;
    logic                dep, redirect, issue, goFlush;
    fsmState_t           state, nextState;
    logic [2:0]          fcnt;

    assign busy[0] = 1'b0;

    genvar r;
    generate
        for (r = 1; r < NUM_REGS; r++) begin : gCnt
            hazard_pending_counter #(.W(CW)) uCnt (
                .Clk      (Clk),
                .Reset    (Reset),
                .load     (issue & bus.RegWrite_DEC & (bus.RegDst_DEC == REG_AW'(r))),
                .load_val (CW'(WB_LAT)),
                .busy     (busy[r])
            );
        end
    endgenerate

    assign dep      = bus.dec_valid & ((bus.RsUse_DEC & busy[bus.Rs_DEC]) | (bus.RtUse_DEC & busy[bus.Rt_DEC]));
    assign redirect = bus.dec_valid & (bus.BranchAND | bus.Jump | bus.JumpRegister);
    assign issue    = bus.dec_valid & ~dep & (state == IDLE);
    // A single-slot flush is fully covered by the redirect cycle itself.
    assign goFlush  = (state == IDLE) & redirect & ~dep & (FLUSH_SLOTS > 1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            fcnt  <= '0;
        end else begin
            state <= nextState;
            fcnt  <= goFlush ? 3'(FLUSH_SLOTS - 1) : (state == FLUSH) ? fcnt - 3'd1 : fcnt;
        end
    end

    always_comb begin
        nextState = (state == IDLE) ? (goFlush ? FLUSH : IDLE) : ((fcnt == 3'd1) ? IDLE : FLUSH);
    end

    always_comb begin
        {bus.PC_write, bus.IFID_write, bus.IF_flush, bus.stall_IDEX} =
            Reset ? 4'b1100 :
            dep ? 4'b0001 :
            ((state == FLUSH) || redirect) ? 4'b1010 : 4'b1100;
        bus.busy_mask = Reset ? '0 : busy;
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.stall_cycles <= '0;
            bus.flush_cycles <= '0;
        end else begin
            bus.stall_cycles <= bus.stall_cycles + 32'(bus.stall_IDEX);
            bus.flush_cycles <= bus.flush_cycles + 32'(bus.IF_flush);
        end
    end
`endif
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: directed vectors against a FLUSH_SLOTS=1 and a FLUSH_SLOTS=3 instance.
module tb_hazard_scoreboard_unit;
    typedef struct packed {
        logic       dv;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rsu;
        logic       rtu;
        logic [4:0] rd;
        logic       rw;
        logic       br;
        logic       j;
        logic       jr;
    } stim_t;

    typedef struct {
        logic        rst;
        stim_t       s;
        logic [3:0]  o;
        logic [31:0] b;
    } vec_t;

    localparam logic [3:0] N = 4'b1100, S = 4'b0001, F = 4'b1010;

    logic  clk, rst;
    stim_t stim;
    int    errors = 0, checks = 0;
    vec_t  vecs[27];

    hazard_scoreboard_unit_if #(.REG_AW(5), .NUM_REGS(32)) ia ();
    hazard_scoreboard_unit_if #(.REG_AW(5), .NUM_REGS(32)) ib ();

    assign {ia.dec_valid, ia.Rs_DEC, ia.Rt_DEC, ia.RsUse_DEC, ia.RtUse_DEC, ia.RegDst_DEC,
            ia.RegWrite_DEC, ia.BranchAND, ia.Jump, ia.JumpRegister} = stim;
    assign {ib.dec_valid, ib.Rs_DEC, ib.Rt_DEC, ib.RsUse_DEC, ib.RtUse_DEC, ib.RegDst_DEC,
            ib.RegWrite_DEC, ib.BranchAND, ib.Jump, ib.JumpRegister} = stim;

    hazard_scoreboard_unit #(.REG_AW(5), .NUM_REGS(32), .WB_LAT(3), .FLUSH_SLOTS(1)) dutA (
        .Clk(clk), .Reset(rst), .bus(ia.slave));
    hazard_scoreboard_unit #(.REG_AW(5), .NUM_REGS(32), .WB_LAT(3), .FLUSH_SLOTS(3)) dutB (
        .Clk(clk), .Reset(rst), .bus(ib.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, bit dv, int rs, int rt, bit rsu, bit rtu, int rd, bit rw,
                                bit br, bit j, bit jr, logic [3:0] o, int breg);
        vec_t v;
        v.rst = r;
        v.s   = '{dv, 5'(rs), 5'(rt), rsu, rtu, 5'(rd), rw, br, j, jr};
        v.o   = o;
        v.b   = (breg < 0) ? 32'd0 : (32'd1 << breg);
        return v;
    endfunction

    task automatic check(input string nm, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got ctl=%b busy=%h expected ctl=%b busy=%h", nm, got[35:32], got[31:0], exp[35:32], exp[31:0]);
        end
    endtask

    task automatic stepB(input string nm, input bit dv, input bit j, input logic [3:0] o);
        stim = '0;
        stim.dv = dv;
        stim.j = j;
        @(negedge clk);
        check(nm, {ib.PC_write, ib.IFID_write, ib.IF_flush, ib.stall_IDEX, ib.busy_mask}, {o, 32'd0});
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with a live redirect and source on the bus
        vecs[0]  = mk(1, 1, 5, 0, 1, 0, 5, 1, 1, 0, 0, N, -1);
        vecs[1]  = mk(1, 1, 5, 0, 1, 0, 5, 1, 1, 0, 0, N, -1);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, -1);
        // producer $8 then a 3-cycle stalled reader, whose own $10 write drains
        vecs[3]  = mk(0, 1, 1, 2, 1, 1, 8, 1, 0, 0, 0, N, -1);
        vecs[4]  = mk(0, 1, 8, 0, 1, 0, 10, 1, 0, 0, 0, S, 8);
        vecs[5]  = mk(0, 1, 8, 0, 1, 0, 10, 1, 0, 0, 0, S, 8);
        vecs[6]  = mk(0, 1, 8, 0, 1, 0, 10, 1, 0, 0, 0, S, 8);
        vecs[7]  = mk(0, 1, 8, 0, 1, 0, 10, 1, 0, 0, 0, N, -1);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 10);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 10);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 10);
        // $0 is never tracked
        vecs[11] = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, N, -1);
        vecs[12] = mk(0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, N, -1);
        vecs[13] = mk(0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, N, -1);
        // jr on a busy $9: stall twice, then one flush cycle
        vecs[14] = mk(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, N, -1);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 9);
        vecs[16] = mk(0, 1, 9, 0, 1, 0, 0, 0, 0, 0, 1, S, 9);
        vecs[17] = mk(0, 1, 9, 0, 1, 0, 0, 0, 0, 0, 1, S, 9);
        vecs[18] = mk(0, 1, 9, 0, 1, 0, 0, 0, 0, 0, 1, F, -1);
        // reload of $4 while its count is 1
        vecs[19] = mk(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, N, -1);
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 4);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 4);
        vecs[22] = mk(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, N, 4);
        vecs[23] = mk(0, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, S, 4);
        vecs[24] = mk(0, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, S, 4);
        vecs[25] = mk(0, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, S, 4);
        vecs[26] = mk(0, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, N, -1);

        for (int i = 0; i < 27; i++) begin
            rst  = vecs[i].rst;
            stim = vecs[i].s;
            @(negedge clk);
            check($sformatf("vecA[%0d]", i),
                  {ia.PC_write, ia.IFID_write, ia.IF_flush, ia.stall_IDEX, ia.busy_mask},
                  {vecs[i].o, vecs[i].b});
            @(posedge clk);
            #1;
        end

`ifdef HAZARD_PERF_EN
        checks++;
        if (ia.stall_cycles !== 32'd8) begin
            errors++;
            $display("FAIL stall_cycles got %0d expected 8", ia.stall_cycles);
        end
        checks++;
        if (ia.flush_cycles !== 32'd1) begin
            errors++;
            $display("FAIL flush_cycles got %0d expected 1", ia.flush_cycles);
        end
`endif

        // three-slot flush on instance B; a second jump mid-flush is ignored
        rst  = 1'b1;
        stim = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        stepB("flushB slot1", 1, 1, F);
        stepB("flushB slot2", 1, 1, F);
        stepB("flushB slot3", 0, 0, F);
        stepB("flushB done", 1, 0, N);
        stepB("flushB idle", 1, 0, N);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
